// File: rtl/dram_arbiter.sv
// Two-port arbiter for the shared single-port data RAM: round-robin or fixed
// priority, bounded bus lock for atomic RMW, and one-cycle read data return.
module dram_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIXED_PRI = 0,
  parameter int unsigned MAX_LOCK  = 8
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  input  logic              i_m0_req,
  input  logic              i_m1_req,
  input  logic              i_m0_we,
  input  logic              i_m1_we,
  input  logic              i_m0_lock,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_rvalid,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_winner_q, last_winner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]         rd_pend_q, rd_pend_d;   // {valid, port}
  logic [1:0]         lock_blk_q, lock_blk_d; // lock ignored after forced release

  logic               en;
  logic [1:0]         req;
  logic [1:0]         lock;
  logic [1:0]         gnt;
  logic               win;
  logic               we_sel;

  always_comb begin
    en   = i_clk_en & i_rstb;
    req  = {i_m1_req, i_m0_req};
    lock = {i_m1_lock, i_m0_lock};
    win  = 1'b0;
    gnt  = '0;
    case (state_q)
      LOCK0: begin
        win    = 1'b0;
        gnt[0] = req[0];
      end
      LOCK1: begin
        win    = 1'b1;
        gnt[1] = req[1];
      end
      default: begin
        if (req == 2'b11) win = (FIXED_PRI != 0) ? 1'b0 : ~last_winner_q;
        else              win = req[1];
        gnt[win] = |req;
      end
    endcase
    if (!en) gnt = '0;
    we_sel = win ? i_m1_we : i_m0_we;
  end

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    lock_cnt_d    = lock_cnt_q;
    rd_pend_d     = rd_pend_q;
    lock_blk_d    = lock_blk_q;
    if (i_clk_en) begin
      rd_pend_d  = {(|gnt) & ~we_sel, win};
      lock_blk_d = lock_blk_q & lock;
      if (|gnt) last_winner_d = win;
      case (state_q)
        IDLE: begin
          if ((|gnt) && lock[win] && !lock_blk_q[win]) begin
            state_d    = win ? LOCK1 : LOCK0;
            lock_cnt_d = CNT_W'(1);
          end
        end
        default: begin
          // The cycle that pushes the count to MAX_LOCK is the last one owned.
          if (!lock[win]) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end else if (lock_cnt_q >= CNT_W'(MAX_LOCK - 1)) begin
            state_d         = IDLE;
            lock_cnt_d      = '0;
            lock_blk_d[win] = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      lock_cnt_q    <= '0;
      rd_pend_q     <= '0;
      lock_blk_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
      rd_pend_q     <= rd_pend_d;
      lock_blk_q    <= lock_blk_d;
    end
  end

  always_comb begin
    o_m0_gnt    = gnt[0];
    o_m1_gnt    = gnt[1];
    o_ram_cs    = |gnt;
    o_ram_we    = (|gnt) & we_sel;
    o_ram_addr  = win ? i_m1_addr  : i_m0_addr;
    o_ram_wdata = win ? i_m1_wdata : i_m0_wdata;
    o_m0_rvalid = rd_pend_q[1] & ~rd_pend_q[0];
    o_m1_rvalid = rd_pend_q[1] &  rd_pend_q[0];
    o_m0_rdata  = o_m0_rvalid ? i_ram_rdata : '0;
    o_m1_rdata  = o_m1_rvalid ? i_ram_rdata : '0;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Two-port arbiter that shares the single-port data RAM between the CPU (port 0) and a secondary master such as a debug or DMA engine (port 1).
- Selects at most one access per enabled cycle and drives the RAM command.
- Returns read data to the owning port one cycle later.
- Supports a bounded bus lock so a master can perform an atomic read-modify-write.

Parameters:
ADDR_W, 16, word address width to RAM
DATA_W, 32, data width
FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins contention
MAX_LOCK, 8, maximum enabled cycles a lock may be held before forced release (>=2)

Ports:
i_clk  in  1  system clock
i_rstb  in  1  asynchronous active-low reset
i_clk_en  in  1  clock enable; all state updates qualified by it
i_m0_req, i_m1_req  in  1  access request
i_m0_we, i_m1_we  in  1  1 = write, 0 = read
i_m0_lock, i_m1_lock  in  1  request/hold exclusive ownership
i_m0_addr, i_m1_addr  in  ADDR_W  word address
i_m0_wdata, i_m1_wdata  in  DATA_W  write data
o_m0_gnt, o_m1_gnt  out  1  access accepted this cycle (combinational)
o_m0_rvalid, o_m1_rvalid  out  1  read data valid (registered)
o_m0_rdata, o_m1_rdata  out  DATA_W  read data
o_ram_cs  out  1  RAM select
o_ram_we  out  1  RAM write enable
o_ram_addr  out  ADDR_W  RAM address
o_ram_wdata  out  DATA_W  RAM write data
i_ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read select

Behaviour:
- State machine: IDLE, LOCK0, LOCK1. Registers:
  - last_winner (1 bit)
  - lock_cnt (clog2(MAX_LOCK+1) bits)
  - rd_pend_port (2 bits: valid + port)
- Reset (async, i_rstb low):
  - state IDLE, last_winner = 1 (port 0 wins the first tie), lock_cnt 0.
  - All o_*_rvalid 0, o_ram_cs 0, o_ram_we 0.
  - rdata outputs are don't-care but driven 0 after reset.
- i_clk_en = 0:
  - All gnt 0, o_ram_cs 0, no register changes.
  - rvalid outputs hold their value.
- IDLE arbitration (i_clk_en = 1):
  - With one requester, it wins.
  - With both requesting: FIXED_PRI = 1 gives port 0; otherwise the port != last_winner wins.
  - Winner's gnt = 1 and its we/addr/wdata are muxed to RAM with o_ram_cs = 1.
  - last_winner updates to the winner.
- Lock entry: the winner with lock = 1 moves state to LOCKn, lock_cnt = 1.
- LOCKn state:
  - Only port n may be granted; the other port's gnt stays 0 even if requesting.
  - Each enabled cycle increments lock_cnt.
  - Exit to IDLE at the first enabled cycle where i_mn_lock = 0, or where lock_cnt reaches MAX_LOCK (forced release).
  - On forced release, port n's access in that cycle is still granted if requested, and lock is ignored until port n deasserts lock for at least one cycle.
  - Arbitration resumes from the next cycle.
- A request without lock in LOCKn by owner n is granted normally and also ends the lock (lock low).
- Read return:
  - A granted read sets rd_pend to that port.
  - Next enabled cycle: o_mX_rvalid = 1 and o_mX_rdata = i_ram_rdata for that port only.
  - rvalid is a one-cycle pulse, cleared when no read was granted the previous enabled cycle.
  - Back-to-back reads, including alternating ports, give one rvalid per cycle with no bubbles.
- Writes: no response beyond gnt; the RAM writes on the grant cycle.
- Read latency: exactly 1 enabled cycle from gnt to rvalid. Write latency: 0.
- Masters must hold req/we/addr/wdata stable until gnt is seen.
- Reset asserted mid-lock or with a read pending: lock is dropped and no rvalid is produced after reset release.

Test Plan:
- Single read, port 0: after reset release, m0 req read addr 0x0010 with RAM word 0xDEADBEEF -> gnt0 same cycle, ram_cs = 1, ram_we = 0, addr 0x0010; next cycle rvalid0 = 1, rdata0 = 0xDEADBEEF; rvalid1 stays 0.
- Round-robin contention: both ports request continuous reads for 6 cycles, FIXED_PRI = 0 -> grants alternate 0,1,0,1,0,1; each rvalid lands on the matching port one cycle later with that port's address data.
- Fixed priority: FIXED_PRI = 1 with both requesting for 4 cycles -> port 0 is granted all 4 and gnt1 stays 0.
- Lock with timeout: m1 holds lock and req with MAX_LOCK = 8 while m0 requests continuously -> m0 starved for exactly 8 enabled cycles, then gnt0 on the next cycle; m1 is not re-locked until its lock drops.
- Clock enable: toggle i_clk_en 1,0,0,1 during a pending read -> no gnt or ram_cs while the enable is low; rvalid appears on the first enabled cycle after the grant.
- Reset mid-lock: assert i_rstb = 0 during LOCK0 with a read pending -> all outputs go to 0 immediately; after release, with both requesting, port 0 wins first and no stale rvalid appears.
